md_issue_buffer: RTL and testbench
==================================

// Module: md_issue_buffer
// PURPOSE
//  E-stage buffer between the pipeline and muldiv. Queues mult/div/mthi/mtlo ops so
//  back-to-back HI/LO ops do not stall the E stage. Issues one op at a time when muldiv
//  is idle; drops queued ops on exception/interrupt flush.
//  Supplies hilo_ready to the hazard unit, which stalls mfhi/mflo until HI/LO is final.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, >= 2
//  MODE_W  4   width of muldiv mode field (`MULDIVMode_*)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  flush       in   1       Req (exception/interrupt): drop queue, suppress issue
//  in_valid    in   1       E stage presents a HI/LO op this cycle
//  in_mode     in   MODE_W  op mode, `MULDIVMode_* encoding
//  in_a        in   32      rs value
//  in_b        in   32      rt value
//  in_ready    out  1       queue can accept; equals (count < DEPTH)
//  md_mode     out  MODE_W  mode to muldiv; `MULDIVMode_NONE when not issuing
//  md_a        out  32      head entry A; 0 when queue empty
//  md_b        out  32      head entry B; 0 when queue empty
//  md_req      out  1       muldiv Req; equals flush
//  md_busy     in   1       muldiv Busy (registered; rises the cycle after Start)
//  hilo_ready  out  1       1 when queue empty, state IDLE and md_busy==0
//  count       out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (async): count=0, ptrs=0, entries=0, state=IDLE; in_ready=1,
//    md_mode=NONE, md_a=md_b=0, hilo_ready=1, md_req=0.
//  - Push: in_valid && in_ready && !flush -> entry written at wr_ptr on clock edge.
//    in_valid while full is ignored (upstream must stall on in_ready=0).
//    No empty-queue bypass: min push-to-issue latency 1 cycle.
//  - Issue condition: count>0 && state==IDLE && !md_busy && !flush.
//    Issue cycle: md_mode = head mode (combinational), head popped at edge.
//  - Compute modes (MULT,MULTU,DIV,DIVU,FDIV,BDS): on issue go IDLE->WAIT.
//    Move modes (MTHI,MTLO): issue, stay IDLE; next move may issue the next cycle.
//  - FSM: IDLE -issue compute-> WAIT; WAIT -md_busy=1-> RUN;
//    WAIT -md_busy=0-> IDLE (guard, 1 cycle max); RUN -md_busy=0-> IDLE.
//    No issue in WAIT or RUN.
//  - Push and pop in the same cycle: count unchanged; legal at full only if a pop occurs
//    (in_ready still reflects pre-edge count, so no push accepted at full).
//  - Pointers wrap modulo DEPTH; count saturates by construction (0..DEPTH).
//  - Flush: md_mode forced NONE same cycle; at edge count=0 and rd_ptr=wr_ptr.
//    Concurrent push is dropped. FSM state is kept: an op already in muldiv completes
//    and muldiv owns that result.
//  - Flush while RUN: queue cleared; hilo_ready rises when md_busy falls.
//  - hilo_ready is combinational from registered state and md_busy only.
//    It is low in any cycle where the queue is non-empty.
//  - Illegal or NONE in_mode pushed: stored, then issued as NONE-equivalent. Muldiv
//    ignores it; FSM stays IDLE.
// STRUCTURE
//  - name.v: add `MULDIVMode_NONE (encoding unused by any op).
//  - name.v: add `MDQ_IDLE/`MDQ_WAIT/`MDQ_RUN (2-bit) state codes.
//  - Sub-module md_fifo: generic synchronous FIFO (data = MODE_W+64 bits, DEPTH).
//    Ports: push, pop, clear, full, empty, count, head. md_issue_buffer holds FSM,
//    issue/gating logic.
// TESTING
//  - Push MULT a=3,b=5 at t0 -> t1 md_mode=MULT, md_a=3, md_b=5; t2 md_busy=1.
//    hilo_ready=0 from t0+1 until md_busy falls, then 1.
//  - Push MULT, DIV, MTHI back-to-back -> DIV issues first cycle after md_busy falls.
//    MTHI issues the next cycle. Never more than one compute in flight.
//  - Fill DEPTH=4 entries with md_busy=1 held -> in_ready=0, count=4.
//    5th push ignored. Release busy: entries drain in FIFO order.
//  - flush with 3 queued, MULT in RUN -> same cycle md_mode=NONE, next cycle count=0.
//    md_busy falls -> hilo_ready=1.
//  - MTLO, MTHI consecutive with md_busy=0 -> issued on consecutive cycles.
//    FSM stays IDLE.
//  - Assert reset mid-RUN with 2 queued, async -> outputs at reset values immediately.
//    First push after release issues normally.

Source files
------------

// File: rtl/md_issue_buffer_pkg.sv
// Shared encodings for the muldiv issue buffer: muldiv op modes and queue FSM states.
package md_issue_buffer_pkg;

  localparam int MODE_W = 4;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_FDIV  = 4'd7;
  localparam logic [3:0] MD_BDS   = 4'd8;

  typedef enum logic [1:0] {
    MDQ_IDLE = 2'd0,
    MDQ_WAIT = 2'd1,
    MDQ_RUN  = 2'd2
  } mdq_state_e;

  // Compute ops occupy muldiv for several cycles and raise md_busy.
  function automatic logic md_is_compute(input logic [3:0] mode);
    return (mode == MD_MULT) || (mode == MD_MULTU) || (mode == MD_DIV) ||
           (mode == MD_DIVU) || (mode == MD_FDIV) || (mode == MD_BDS);
  endfunction

  function automatic logic md_is_move(input logic [3:0] mode);
    return (mode == MD_MTHI) || (mode == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_fifo.sv
// Generic synchronous FIFO with combinational head, occupancy count and a clear
// that discards all entries in one edge.
module md_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_buffer.sv
// E-stage queue in front of muldiv: buffers HI/LO ops, issues one at a time when
// muldiv is idle, and tells the hazard unit when HI/LO is final.
module md_issue_buffer
  import md_issue_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int MODE_W = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  output logic              in_ready,
  output logic [MODE_W-1:0] md_mode,
  output logic [31:0]       md_a,
  output logic [31:0]       md_b,
  output logic              md_req,
  input  logic              md_busy,
  output logic              hilo_ready,
  output logic [CW-1:0]     count
);

  localparam int EW = MODE_W + 64;

  logic [EW-1:0]     head;
  logic [MODE_W-1:0] head_mode;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              issue;
  mdq_state_e        state_q;

  assign head_mode = head[EW-1:64];
  assign push      = in_valid && !fifo_full && !flush;
  assign issue     = !fifo_empty && (state_q == MDQ_IDLE) && !md_busy && !flush;

  md_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .pop      (issue),
    .clear    (flush),
    .push_data({in_mode, in_a, in_b}),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count),
    .head     (head)
  );

  // Unknown or NONE modes still leave the queue but reach muldiv as NONE.
  always_comb begin
    md_mode = MODE_W'(MD_NONE);
    if (issue && (md_is_compute(head_mode) || md_is_move(head_mode))) md_mode = head_mode;
  end

  assign md_a       = fifo_empty ? 32'd0 : head[63:32];
  assign md_b       = fifo_empty ? 32'd0 : head[31:0];
  assign in_ready   = !fifo_full;
  assign md_req     = flush;
  assign hilo_ready = fifo_empty && (state_q == MDQ_IDLE) && !md_busy;

  // WAIT covers the one cycle before muldiv's registered busy rises; flush leaves
  // the state alone so an op already inside muldiv is tracked to completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDQ_IDLE;
    end else begin
      case (state_q)
        MDQ_IDLE: if (issue && md_is_compute(head_mode)) state_q <= MDQ_WAIT;
        MDQ_WAIT: state_q <= md_busy ? MDQ_RUN : MDQ_IDLE;
        MDQ_RUN:  if (!md_busy) state_q <= MDQ_IDLE;
        default:  state_q <= MDQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_buffer.sv
// Bench for md_issue_buffer: fixed vector table, then scoreboard-checked scenarios
// driven against a behavioural muldiv with configurable latency.
module tb_md_issue_buffer;
  import md_issue_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [3:0]  in_mode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_ready;
  logic [3:0]  md_mode;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_req;
  logic        md_busy;
  logic        hilo_ready;
  logic [2:0]  count;

  md_issue_buffer #(.DEPTH(4), .MODE_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .md_mode(md_mode), .md_a(md_a),
    .md_b(md_b), .md_req(md_req), .md_busy(md_busy), .hilo_ready(hilo_ready), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [3:0]  e_mode;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_rdy;
    logic        e_hilo;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic v, input logic [3:0] m, input logic [31:0] a,
                              input logic [31:0] b, input logic busy, input logic [3:0] em,
                              input logic [31:0] ea, input logic [31:0] eb, input logic er,
                              input logic eh, input logic [2:0] ec);
    vec_t r;
    r.v = v; r.m = m; r.a = a; r.b = b; r.busy = busy;
    r.e_mode = em; r.e_a = ea; r.e_b = eb; r.e_rdy = er; r.e_hilo = eh; r.e_cnt = ec;
    return r;
  endfunction

  // ---------------- scoreboard and reference ----------------
  typedef struct {
    logic [3:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t sbq[$];
  int  mcount   = 0;
  int  mstate   = 0;   // 0 idle, 1 waiting for busy, 2 running
  int  busy_cnt = 0;
  int  lat      = 3;
  logic [3:0] legal[8];

  function automatic logic is_comp(input logic [3:0] m);
    return m inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
  endfunction

  task automatic cyc(input logic v, input logic [3:0] m, input logic [31:0] a,
                     input logic [31:0] b, input logic fl);
    logic exp_issue;
    logic comp_issued;
    logic busy_now;
    op_t  op;
    int   pre_count;
    in_valid = v; in_mode = m; in_a = a; in_b = b; flush = fl;
    busy_now = (busy_cnt > 0);
    md_busy  = busy_now;
    #3;
    pre_count   = mcount;
    exp_issue   = (mcount > 0) && (mstate == 0) && !busy_now && !fl;
    comp_issued = 1'b0;
    chk("in_ready", in_ready, pre_count < 4);
    chk("count", count, pre_count);
    chk("md_req", md_req, fl);
    chk("hilo_ready", hilo_ready, (pre_count == 0) && (mstate == 0) && !busy_now);
    if (pre_count > 0) begin
      chk("md_a_head", md_a, sbq[0].a);
      chk("md_b_head", md_b, sbq[0].b);
    end else begin
      chk("md_a_empty", md_a, 32'd0);
      chk("md_b_empty", md_b, 32'd0);
    end
    if (exp_issue) begin
      op = sbq.pop_front();
      chk("issue_mode", md_mode, op.mode);
      $display("issue mode=%0d a=%0h b=%0h t=%0t", md_mode, md_a, md_b, $time);
      comp_issued = is_comp(op.mode);
    end else begin
      chk("no_issue", md_mode, MD_NONE);
    end
    if (fl) begin
      sbq.delete();
      mcount = 0;
    end else begin
      if (exp_issue) mcount--;
      if (v && pre_count < 4) begin
        op.mode = m; op.a = a; op.b = b;
        sbq.push_back(op);
        mcount++;
      end
    end
    case (mstate)
      0: if (comp_issued) mstate = 1;
      1: mstate = busy_now ? 2 : 0;
      default: if (!busy_now) mstate = 0;
    endcase
    @(posedge clk); #1;
    if (busy_cnt > 0) busy_cnt--;
    if (comp_issued) busy_cnt = lat;
  endtask

  task automatic idle();
    cyc(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (mcount == 0 && mstate == 0 && busy_cnt == 0) done = 1'b1;
      else idle();
    end
    chk("drain_done", done, 1'b1);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    legal[0] = MD_MULT; legal[1] = MD_MULTU; legal[2] = MD_DIV;  legal[3] = MD_DIVU;
    legal[4] = MD_MTHI; legal[5] = MD_MTLO;  legal[6] = MD_FDIV; legal[7] = MD_BDS;

    tbl[0]  = mk(0, MD_NONE, 0, 0, 0,        MD_NONE, 0, 0, 1, 1, 0);
    tbl[1]  = mk(1, MD_MULT, 3, 5, 0,        MD_NONE, 0, 0, 1, 1, 0);
    tbl[2]  = mk(0, MD_NONE, 0, 0, 0,        MD_MULT, 3, 5, 1, 0, 1);
    tbl[3]  = mk(0, MD_NONE, 0, 0, 1,        MD_NONE, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, MD_NONE, 0, 0, 1,        MD_NONE, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, MD_NONE, 0, 0, 0,        MD_NONE, 0, 0, 1, 0, 0);
    tbl[6]  = mk(0, MD_NONE, 0, 0, 0,        MD_NONE, 0, 0, 1, 1, 0);
    tbl[7]  = mk(1, MD_MTLO, 32'h11, 32'h22, 0, MD_NONE, 0, 0, 1, 1, 0);
    tbl[8]  = mk(1, MD_MTHI, 32'h33, 32'h44, 0, MD_MTLO, 32'h11, 32'h22, 1, 0, 1);
    tbl[9]  = mk(0, MD_NONE, 0, 0, 0,        MD_MTHI, 32'h33, 32'h44, 1, 0, 1);
    tbl[10] = mk(0, MD_NONE, 0, 0, 0,        MD_NONE, 0, 0, 1, 1, 0);
    tbl[11] = mk(1, 4'hF, 1, 2, 0,           MD_NONE, 0, 0, 1, 1, 0);
    tbl[12] = mk(0, MD_NONE, 0, 0, 0,        MD_NONE, 1, 2, 1, 0, 1);
    tbl[13] = mk(0, MD_NONE, 0, 0, 0,        MD_NONE, 0, 0, 1, 1, 0);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = MD_NONE;
    in_a = 32'd0; in_b = 32'd0; md_busy = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_md_mode", md_mode, MD_NONE);
    chk("rst_hilo", hilo_ready, 1'b1);
    chk("rst_count", count, 3'd0);
    chk("rst_md_req", md_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].v; in_mode = tbl[i].m; in_a = tbl[i].a; in_b = tbl[i].b;
      md_busy = tbl[i].busy; flush = 1'b0;
      #3;
      chk($sformatf("tbl%0d_md_mode", i), md_mode, tbl[i].e_mode);
      chk($sformatf("tbl%0d_md_a", i), md_a, tbl[i].e_a);
      chk($sformatf("tbl%0d_md_b", i), md_b, tbl[i].e_b);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_hilo", i), hilo_ready, tbl[i].e_hilo);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      $display("vec %0d mode=%0d a=%0h b=%0h cnt=%0d hilo=%0d", i, md_mode, md_a, md_b,
               count, hilo_ready);
      @(posedge clk); #1;
    end

    // Back-to-back MULT, DIV, MTHI.
    lat = 3;
    cyc(1, MD_MULT, 32'd3, 32'd5, 0);
    cyc(1, MD_DIV, 32'd100, 32'd7, 0);
    cyc(1, MD_MTHI, 32'd9, 32'd0, 0);
    drain();

    // Fill while muldiv is busy; fifth push must be ignored.
    lat = 20;
    cyc(1, MD_MULT, 32'd1, 32'd1, 0);
    cyc(1, MD_DIVU, 32'hA1, 32'hB1, 0);
    cyc(1, MD_MULTU, 32'hA2, 32'hB2, 0);
    cyc(1, MD_MTLO, 32'hA3, 32'hB3, 0);
    cyc(1, MD_FDIV, 32'hA4, 32'hB4, 0);
    cyc(1, MD_BDS, 32'hA5, 32'hB5, 0);
    chk("full_count", count, 3'd4);
    chk("full_in_ready", in_ready, 1'b0);
    lat = 2;
    drain();

    // Flush with three queued while a MULT is running.
    lat = 15;
    cyc(1, MD_MULT, 32'd6, 32'd7, 0);
    cyc(1, MD_MULTU, 32'd8, 32'd9, 0);
    cyc(1, MD_DIV, 32'd10, 32'd11, 0);
    cyc(1, MD_MTLO, 32'd12, 32'd13, 0);
    idle();
    cyc(1, MD_MTHI, 32'd14, 32'd15, 1);
    drain();

    // MTLO then MTHI with muldiv idle.
    cyc(1, MD_MTLO, 32'h55, 32'h0, 0);
    cyc(1, MD_MTHI, 32'h66, 32'h0, 0);
    drain();

    // Asynchronous reset mid-RUN with two queued.
    lat = 15;
    cyc(1, MD_MULT, 32'd2, 32'd3, 0);
    cyc(1, MD_DIV, 32'd4, 32'd5, 0);
    cyc(1, MD_MTHI, 32'd6, 32'd7, 0);
    idle();
    in_valid = 1'b0; flush = 1'b0;
    #2;
    reset = 1'b1; md_busy = 1'b0;
    #1;
    chk("arst_count", count, 3'd0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_md_mode", md_mode, MD_NONE);
    chk("arst_md_a", md_a, 32'd0);
    chk("arst_md_b", md_b, 32'd0);
    chk("arst_hilo", hilo_ready, 1'b1);
    chk("arst_md_req", md_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete(); mcount = 0; mstate = 0; busy_cnt = 0;
    lat = 3;
    cyc(1, MD_MULT, 32'd3, 32'd5, 0);
    drain();

    // Mixed traffic with occasional flushes.
    lat = 2;
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 1)), legal[$urandom_range(0, 7)], $urandom, $urandom,
          ($urandom_range(0, 15) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
